// File: rtl/seg14_scan_driver.sv
// seg14_scan_driver: time-multiplexes g_num_digits 16-bit 14-segment words onto
// one segment bus with one-hot digit enables. A frame snapshot is taken at every
// frame start; each digit slot is 16 cycles with a blank phase 0 and PWM dimming.
module seg14_scan_driver #(
    parameter int g_num_digits = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [16*g_num_digits-1:0] i_14seg_cntrls,
    input  logic                      i_enable,
    input  logic [3:0]                i_brightness,
    output logic [15:0]               o_seg,
    output logic [g_num_digits-1:0]   o_digit_sel,
    output logic                      o_frame_start
);

    localparam int DIGIT_W = (g_num_digits > 1) ? $clog2(g_num_digits) : 1;
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(g_num_digits - 1);
    localparam logic [g_num_digits-1:0] SEL_ONE = g_num_digits'(1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               state, state_nxt;
    logic [DIGIT_W-1:0]   digit_cnt, digit_nxt;
    logic [3:0]           phase_cnt, phase_nxt;
    logic                 load;
    logic                 active;
    logic [15:0]          frame_buf [g_num_digits];
    logic [3:0]           bright_lat;
    logic [15:0]          seg_nxt;
    logic [g_num_digits-1:0] sel_nxt;

    // State and scan position registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            digit_cnt <= '0;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            digit_cnt <= digit_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    // Next scan position; a frame load happens whenever the next slot is digit 0 phase 0
    always_comb begin
        state_nxt = state;
        digit_nxt = digit_cnt;
        phase_nxt = phase_cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                digit_nxt = '0;
                phase_nxt = '0;
                if (i_enable) begin
                    state_nxt = SCAN;
                    load      = 1'b1;
                end
            end
            SCAN: begin
                if (!i_enable) begin
                    state_nxt = IDLE;
                    digit_nxt = '0;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase_cnt + 4'd1;
                    if (phase_cnt == 4'd15)
                        digit_nxt = (digit_cnt == LAST_DIGIT) ? '0 : digit_cnt + DIGIT_W'(1);
                    load = (digit_nxt == '0) && (phase_nxt == 4'd0);
                end
            end
            default: begin
                state_nxt = IDLE;
                digit_nxt = '0;
                phase_nxt = '0;
            end
        endcase
    end

    // Output values for the slot being entered; phase 0 is always blank, so the
    // brightness latched on the load edge is valid before it is first used
    always_comb begin
        active  = (state_nxt == SCAN) && (phase_nxt != 4'd0) && (phase_nxt <= bright_lat);
        seg_nxt = '0;
        sel_nxt = '0;
        if (active) begin
            seg_nxt = frame_buf[digit_nxt];
            sel_nxt = SEL_ONE << digit_nxt;
        end
    end

    // Frame snapshot and brightness latch, refreshed only at frame start
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int d = 0; d < g_num_digits; d++)
                frame_buf[d] <= '0;
            bright_lat <= '0;
        end else if (load) begin
            for (int d = 0; d < g_num_digits; d++)
                frame_buf[d] <= i_14seg_cntrls[16*d +: 16];
            bright_lat <= i_brightness;
        end
    end

    // Registered panel outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_seg         <= '0;
            o_digit_sel   <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_seg         <= seg_nxt;
            o_digit_sel   <= sel_nxt;
            o_frame_start <= load;
        end
    end

endmodule
